seq_bit_serializer: RTL and testbench
=====================================

Name: seq_bit_serializer

Overview:
Parallel-to-serial stage directly upstream of the 1011 shift-register sequence detector. It accepts a WIDTH-bit word over a valid/ready handshake and drives it MSB-first, one bit per clk, onto the detector's serial input x. Back-to-back words stream with no idle cycle between them, so patterns that straddle a word boundary are still detected.

Parameters:
WIDTH, 8, data word width in bits; legal range 1 to 32.

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
din  input  WIDTH  parallel word to serialize
din_valid  input  1  din holds a valid word
din_ready  output  1  block can accept din this cycle (combinational from registered state)
x  output  1  serial data bit to the detector, registered
x_valid  output  1  x carries a live bit this cycle, registered
last  output  1  high while x carries the final bit of the current frame, registered

Behaviour:
- Reset (reset=0, asynchronous): x=0, x_valid=0, last=0, shift register=0, bit counter=0, state=IDLE.
- Internal state: shreg[WIDTH-1:0], cnt (bits remaining after the current one), frame-active flag (equal to x_valid).
- din_ready = !x_valid || last.
  - High in IDLE.
  - High during the final-bit cycle, which allows gapless streaming.
  - Low otherwise.
- Accept: a word is accepted when din_valid && din_ready at a rising edge. On that edge:
  - x <= din[WIDTH-1], x_valid <= 1
  - shreg <= din << 1, cnt <= FRAME-1
  - last <= (FRAME==1)
  - FRAME = WIDTH, or WIDTH+1 with the parity feature.
- Latency: the MSB appears on x in the cycle following acceptance.
- SHIFT with cnt>0 (no accept possible, since din_ready=0):
  - x <= shreg[WIDTH-1], shreg <= shreg << 1, cnt <= cnt-1
  - last <= (cnt==1)
- Final-bit cycle (last=1):
  - With an accept on that edge: behave as Accept. There is no bubble, and x_valid stays 1.
  - Without an accept: x <= 0, x_valid <= 0, last <= 0, return to IDLE.
- din and din_valid are ignored whenever din_ready=0. An in-flight word is never corrupted or restarted.
- x is forced to 0 whenever x_valid=0, so the detector sees zeros when idle.
- Reset asserted mid-frame aborts the frame immediately: outputs go to their reset values and the remaining bits are discarded. After reset deasserts, the next accept starts a fresh frame.
- WIDTH=1: every frame is a single cycle with last=1, and a continuous din_valid gives one bit per clk.

Optional Feature:
Macro SERIALIZER_PARITY_EN.
- Defined:
  - One even-parity bit, the XOR of all bits of the accepted din, is appended after the LSB.
  - FRAME = WIDTH+1, and last is asserted on the parity bit, not the LSB.
  - Parity is captured at accept time, so later changes on din do not affect it.
- Undefined:
  - FRAME = WIDTH, and no parity logic is synthesized.

Test Plan:
1. WIDTH=4, feature off: after reset release, din=4'b1011 with din_valid for one cycle. Required: x=1,0,1,1 on the 4 following cycles; x_valid=1 for exactly those 4 cycles; last=1 only on the 4th; din_ready=0 on cycles 1-3, then 1; the downstream detector z pulses once.
2. WIDTH=4, back-to-back: din=4'b1011, then 4'b0110 presented with din_valid held high. Required: second accept occurs on the last-bit cycle of the first word; x stream 1,0,1,1,0,1,1,0 with x_valid continuously 1 for 8 cycles; detector z pulses at stream bits 4 and 7 (overlapping 1011).
3. Busy-ignore: while serializing 4'b1011, drive din=4'b0000 with din_valid=1 on cycles 1-2 only. Required: output remains 1,0,1,1; x_valid drops after bit 4; no second frame.
4. Reset mid-frame: assert reset=0 asynchronously (between clock edges) after bit 2 of 4'b1011. Required: x, x_valid and last go to 0 immediately without waiting for clk. After release, din=4'b1101 produces a clean 1,1,0,1.
5. SERIALIZER_PARITY_EN defined, WIDTH=4: din=4'b1011. Required: x=1,0,1,1,1 (parity 1); last on the 5th bit. Then din=4'b1001: x=1,0,0,1,0.
6. WIDTH=1: din_valid held 1 with din toggling 1,0,1,1. Required: x follows one cycle later with x_valid and last constantly 1, and din_ready constantly 1.

Source files
------------

// File: rtl/seq_bit_serializer.sv
// rtl/seq_bit_serializer.sv - parallel-to-serial front end for the 1011 sequence detector
//
// Purpose:
//   Accepts a WIDTH-bit word on a valid/ready handshake and shifts it out
//   MSB-first, one bit per clk, on x. A new word may be accepted on the
//   final-bit cycle of the current frame, so consecutive words stream
//   with no idle cycle between them.
//
// Configuration:
//   SERIALIZER_PARITY_EN - when defined, an even-parity bit (XOR of the
//   accepted word) follows the LSB and carries last. When undefined, a
//   frame is exactly WIDTH bits and no parity logic exists.
//
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous active-low reset
//   din        in   WIDTH  parallel word
//   din_valid  in   1      din holds a valid word
//   din_ready  out  1      word can be accepted this cycle
//   x          out  1      serial bit (registered, 0 when idle)
//   x_valid    out  1      x carries a live bit (registered)
//   last       out  1      x carries the final bit of the frame (registered)

module seq_bit_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             x,
  output logic             x_valid,
  output logic             last
);

`ifdef SERIALIZER_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  localparam int FRAME = WIDTH + PAR_W;
  // Sized to hold FRAME-1; the +1 keeps it at least one bit wide when FRAME==1.
  localparam int CW    = $clog2(FRAME + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic             x_q;
  logic             x_valid_q;
  logic             last_q;
  logic [FRAME-1:0] shreg_q;
  logic [CW-1:0]    cnt_q;

  // Whole frame as it will leave the block, MSB first.
  logic [FRAME-1:0] frame_d;
  logic             accept_d;

`ifdef SERIALIZER_PARITY_EN
  // Parity is computed from din at the accept edge and stored with the data,
  // so din may change freely afterwards.
  assign frame_d = {din, ^din};
`else
  assign frame_d = din;
`endif

  // Ready in IDLE and on the final bit, which is what makes streaming gapless.
  assign din_ready = !x_valid_q || last_q;
  assign accept_d  = din_valid && din_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      last_q    <= 1'b0;
      shreg_q   <= '0;
      cnt_q     <= '0;
    end else if (accept_d) begin
      // Load: first bit goes straight to x, the rest wait in shreg.
      state_q   <= SHIFT;
      x_q       <= frame_d[FRAME-1];
      x_valid_q <= 1'b1;
      last_q    <= (FRAME == 1);
      shreg_q   <= frame_d << 1;
      cnt_q     <= CW'(FRAME - 1);
    end else if (state_q == SHIFT) begin
      if (cnt_q != '0) begin
        x_q     <= shreg_q[FRAME-1];
        shreg_q <= shreg_q << 1;
        cnt_q   <= cnt_q - CW'(1);
        last_q  <= (cnt_q == CW'(1));
      end else begin
        // Final bit was on x and nothing new arrived: go quiet with x=0.
        state_q   <= IDLE;
        x_q       <= 1'b0;
        x_valid_q <= 1'b0;
        last_q    <= 1'b0;
      end
    end
  end

  assign x       = x_q;
  assign x_valid = x_valid_q;
  assign last    = last_q;

endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb/tb_seq_bit_serializer.sv - directed bench for seq_bit_serializer (WIDTH=4 and WIDTH=1)

module tb_seq_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int F4 = 4 + PW;
  localparam int F1 = 1 + PW;

  logic       clk;
  logic       reset;
  logic [3:0] din4;
  logic       dv4;
  logic       rdy4, x4, xv4, last4;
  logic [0:0] din1;
  logic       dv1;
  logic       rdy1, x1, xv1, last1;

  int n_cmp;
  int n_bad;
  int zcnt;
  logic [2:0] win;

  seq_bit_serializer #(.WIDTH(4)) u_dut4 (
    .clk       (clk),
    .reset     (reset),
    .din       (din4),
    .din_valid (dv4),
    .din_ready (rdy4),
    .x         (x4),
    .x_valid   (xv4),
    .last      (last4)
  );

  seq_bit_serializer #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .reset     (reset),
    .din       (din1),
    .din_valid (dv1),
    .din_ready (rdy1),
    .x         (x1),
    .x_valid   (xv1),
    .last      (last1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference 1011 shift-register detector on the WIDTH=4 serial stream.
  initial begin
    zcnt = 0;
    win  = 3'b000;
  end
  always @(posedge clk) begin
    if ({win, x4} == 4'b1011) zcnt = zcnt + 1;
    win = {win[1:0], x4};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [F4-1:0] fb(input logic [3:0] w);
`ifdef SERIALIZER_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic check_idle4(input string tag);
    check({tag, " x"}, x4, 1'b0);
    check({tag, " x_valid"}, xv4, 1'b0);
    check({tag, " last"}, last4, 1'b0);
    check({tag, " din_ready"}, rdy4, 1'b1);
  endtask

  task automatic run_frame(input logic [3:0] w, input string tag);
    logic [F4-1:0] bits;
    bits = fb(w);
    din4 = w;
    dv4  = 1'b1;
    tick();
    dv4  = 1'b0;
    din4 = 4'h0;
    for (int i = 0; i < F4; i++) begin
      check($sformatf("%s bit%0d x", tag, i), x4, bits[F4-1-i]);
      check($sformatf("%s bit%0d x_valid", tag, i), xv4, 1'b1);
      check($sformatf("%s bit%0d last", tag, i), last4, (i == F4 - 1));
      check($sformatf("%s bit%0d din_ready", tag, i), rdy4, (i == F4 - 1));
      tick();
    end
    check_idle4({tag, " after"});
  endtask

  initial begin
    logic [2*F4-1:0] bb;
    logic [F4-1:0]   b3;
    logic [3:0]      seq1;
    int              z0;

    n_cmp = 0;
    n_bad = 0;
    reset = 1'b0;
    din4  = 4'h0;
    dv4   = 1'b0;
    din1  = 1'b0;
    dv1   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_idle4("reset");
    check("reset w1 x_valid", xv1, 1'b0);
    check("reset w1 last", last1, 1'b0);
    check("reset w1 din_ready", rdy1, 1'b1);

    // Single word 1011: one detector hit.
    z0 = zcnt;
    run_frame(4'b1011, "t1");
    check("t1 z count", zcnt - z0, 1);

    // Back-to-back 1011 then 0110 with valid held.
    bb   = {fb(4'b1011), fb(4'b0110)};
    z0   = zcnt;
    din4 = 4'b1011;
    dv4  = 1'b1;
    tick();
    din4 = 4'b0110;
    for (int i = 0; i < 2 * F4; i++) begin
      check($sformatf("t2 bit%0d x", i), x4, bb[2*F4-1-i]);
      check($sformatf("t2 bit%0d x_valid", i), xv4, 1'b1);
      check($sformatf("t2 bit%0d last", i), last4, (i == F4 - 1) || (i == 2 * F4 - 1));
      if (i == F4) dv4 = 1'b0;
      tick();
    end
    check_idle4("t2 after");
    check("t2 z count", zcnt - z0, 2);

    // Busy-ignore: garbage offered while the word is in flight.
    b3   = fb(4'b1011);
    din4 = 4'b1011;
    dv4  = 1'b1;
    tick();
    for (int i = 0; i < F4; i++) begin
      check($sformatf("t3 bit%0d x", i), x4, b3[F4-1-i]);
      check($sformatf("t3 bit%0d x_valid", i), xv4, 1'b1);
      if (i < 2) begin
        din4 = 4'b0000;
        dv4  = 1'b1;
      end else begin
        dv4  = 1'b0;
      end
      tick();
    end
    check_idle4("t3 after");
    tick();
    check_idle4("t3 after2");

    // Asynchronous reset after bit 2.
    din4 = 4'b1011;
    dv4  = 1'b1;
    tick();
    dv4  = 1'b0;
    check("t4 bit0 x", x4, 1'b1);
    tick();
    check("t4 bit1 x", x4, 1'b0);
    check("t4 bit1 x_valid", xv4, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("t4 async x_valid", xv4, 1'b0);
    check("t4 async x", x4, 1'b0);
    check("t4 async last", last4, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_idle4("t4 released");
    run_frame(4'b1101, "t4b");

    // Parity-sensitive vectors (plain 4-bit frames when parity is off).
    run_frame(4'b1011, "t5a");
    run_frame(4'b1001, "t5b");

    // WIDTH=1 instance.
`ifdef SERIALIZER_PARITY_EN
    din1 = 1'b1;
    dv1  = 1'b1;
    tick();
    dv1  = 1'b0;
    check("t6 bit0 x", x1, 1'b1);
    check("t6 bit0 last", last1, 1'b0);
    check("t6 bit0 din_ready", rdy1, 1'b0);
    tick();
    check("t6 par x", x1, 1'b1);
    check("t6 par last", last1, 1'b1);
    check("t6 par din_ready", rdy1, 1'b1);
    tick();
    check("t6 end x_valid", xv1, 1'b0);
`else
    seq1 = 4'b1011;
    dv1  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      din1 = seq1[3-i];
      check($sformatf("t6 pre%0d din_ready", i), rdy1, 1'b1);
      tick();
      check($sformatf("t6 bit%0d x", i), x1, seq1[3-i]);
      check($sformatf("t6 bit%0d x_valid", i), xv1, 1'b1);
      check($sformatf("t6 bit%0d last", i), last1, 1'b1);
      check($sformatf("t6 bit%0d din_ready", i), rdy1, 1'b1);
    end
    dv1 = 1'b0;
    tick();
    check("t6 end x_valid", xv1, 1'b0);
    check("t6 end x", x1, 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
